// File: rtl/morse_msg_seq.sv
// morse_msg_seq
//
// Holds a runtime-loadable message in a small character buffer. It hands the
// characters one at a time to a Morse encoder over a valid/ready handshake,
// and inserts a fixed inter-letter gap after every accepted character. It can
// send the message once (one-shot) or loop over it until aborted (beacon).
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data buffer write port, only honoured while not busy
//   msg_len              message length, clamped to MAX_LEN, latched on start
//   repeat_en            beacon mode, latched on start
//   start                begin a message (level or pulse)
//   abort                return to idle at once, without a done pulse
//   char_valid/char_ready handshake with the encoder
//   char_out/char_idx    current character and its buffer index
//   busy                 message in progress (PRESENT or GAP)
//   done                 one-cycle pulse when a one-shot message completes
module morse_msg_seq #(
    parameter int CHAR_W      = 8,
    parameter int MAX_LEN     = 16,
    parameter int IDX_W       = 4,
    parameter int SLOT_CYCLES = 18,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [IDX_W:0]    msg_len,
    input  logic              repeat_en,
    input  logic              start,
    input  logic              abort,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [CHAR_W-1:0] char_out,
    output logic [IDX_W-1:0]  char_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [IDX_W:0]     len_q;
    logic [IDX_W:0]     len_next;
    logic               repeat_q;
    logic               repeat_next;
    logic [IDX_W:0]     len_clamped;
    logic [IDX_W:0]     idx_inc;

    logic [CHAR_W-1:0]  mem [MAX_LEN];

    // Buffer is deliberately not reset. Writes are blocked while a message is
    // in flight so the character being presented can never change under the
    // encoder.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Requests longer than the buffer simply send the whole buffer.
    assign len_clamped = (msg_len > (IDX_W+1)'(MAX_LEN)) ? (IDX_W+1)'(MAX_LEN) : msg_len;

    // One bit wider than idx so that idx+1 == MAX_LEN compares correctly.
    assign idx_inc = {1'b0, idx} + (IDX_W+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            len_q    <= '0;
            repeat_q <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            cnt      <= cnt_next;
            len_q    <= len_next;
            repeat_q <= repeat_next;
        end
    end

    // Next-state and output decode. Abort wins over everything outside IDLE,
    // including an accept on the same edge (that character still went out).
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        cnt_next    = cnt;
        len_next    = len_q;
        repeat_next = repeat_q;
        char_valid  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    len_next    = len_clamped;
                    repeat_next = repeat_en;
                    idx_next    = '0;
                    state_next  = (len_clamped == '0) ? DONE : PRESENT;
                end
            end
            PRESENT: begin
                char_valid = 1'b1;
                busy       = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else if (char_ready) begin
                    state_next = GAP;
                    cnt_next   = CNT_W'(SLOT_CYCLES - 1);
                end
            end
            GAP: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else if (cnt == '0) begin
                    if (idx_inc < len_q) begin
                        idx_next   = idx + IDX_W'(1);
                        state_next = PRESENT;
                    end else if (repeat_q) begin
                        idx_next   = '0;
                        state_next = PRESENT;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                done       = 1'b1;
                idx_next   = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // char_out is forced to zero outside PRESENT so it reads zero after reset
    // even though the buffer itself holds arbitrary data.
    assign char_out = (state == PRESENT) ? mem[idx] : '0;
    assign char_idx = idx;

endmodule

// File: tb/tb_morse_msg_seq.sv
// tb_morse_msg_seq
//
// Directed bench for morse_msg_seq. Each scenario task drives its own
// stimulus and compares outputs against hand-computed values. Inputs change
// 1 time unit after a rising edge and outputs are sampled at that same point.
module tb_morse_msg_seq;

    localparam int CHAR_W      = 8;
    localparam int MAX_LEN     = 16;
    localparam int IDX_W       = 4;
    localparam int SLOT_CYCLES = 18;
    localparam int CNT_W       = 8;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [CHAR_W-1:0] wr_data;
    logic [IDX_W:0]    msg_len;
    logic              repeat_en;
    logic              start;
    logic              abort;
    logic              char_valid;
    logic              char_ready;
    logic [CHAR_W-1:0] char_out;
    logic [IDX_W-1:0]  char_idx;
    logic              busy;
    logic              done;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] sos_exp [3] = '{8'h53, 8'h4F, 8'h53};
    logic [7:0] ab_exp  [5] = '{8'h41, 8'h42, 8'h41, 8'h42, 8'h41};
    logic [3:0] ab_idx  [5] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0};

    morse_msg_seq #(
        .CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .IDX_W(IDX_W),
        .SLOT_CYCLES(SLOT_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .repeat_en(repeat_en),
        .start(start), .abort(abort),
        .char_valid(char_valid), .char_ready(char_ready),
        .char_out(char_out), .char_idx(char_idx),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_char(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic start_msg(input logic [4:0] len, input logic rep);
        msg_len   = len;
        repeat_en = rep;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // Steps at least once (the accept edge), then until char_valid or bound.
    task automatic wait_valid(input int max, output int n, output bit saw_done);
        n = 0;
        saw_done = 1'b0;
        do begin
            step();
            n++;
            if (done) saw_done = 1'b1;
        end while (!char_valid && n < max);
    endtask

    // Steps at least once, then until done or bound.
    task automatic wait_done(input int max, output int n, output bit saw_valid);
        n = 0;
        saw_valid = 1'b0;
        do begin
            step();
            n++;
            if (char_valid) saw_valid = 1'b1;
        end while (!done && n < max);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++; if (char_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b, expected 0", char_valid); end
        vectors++; if (char_out !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_char_out: got %h, expected 00", char_out); end
        vectors++; if (char_idx !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_char_idx: got %0d, expected 0", char_idx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
        #14;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sos();
        int n;
        bit flag;
        write_char(4'd0, 8'h53);
        write_char(4'd1, 8'h4F);
        write_char(4'd2, 8'h53);
        char_ready = 1'b1;
        start_msg(5'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            vectors++; if (char_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL sos_valid k=%0d: got %b, expected 1", k, char_valid); end
            vectors++; if (char_out !== sos_exp[k]) begin miscompares++; $display("[TB] FAIL sos_char k=%0d: got %h, expected %h", k, char_out, sos_exp[k]); end
            vectors++; if (char_idx !== k[3:0]) begin miscompares++; $display("[TB] FAIL sos_idx k=%0d: got %0d, expected %0d", k, char_idx, k); end
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL sos_busy k=%0d: got %b, expected 1", k, busy); end
            if (k < 2) begin
                wait_valid(60, n, flag);
                vectors++; if (n != 19) begin miscompares++; $display("[TB] FAIL sos_spacing k=%0d: got %0d cycles, expected 19", k, n); end
                vectors++; if (flag !== 1'b0) begin miscompares++; $display("[TB] FAIL sos_early_done k=%0d: got %b, expected 0", k, flag); end
            end else begin
                wait_done(60, n, flag);
                vectors++; if (n != 19) begin miscompares++; $display("[TB] FAIL sos_done_latency: got %0d cycles, expected 19", n); end
                vectors++; if (flag !== 1'b0) begin miscompares++; $display("[TB] FAIL sos_extra_valid: got %b, expected 0", flag); end
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL sos_busy_at_done: got %b, expected 0", busy); end
            end
        end
        step();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL sos_done_width: got %b, expected 0", done); end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        bit flag;
        char_ready = 1'b1;
        start_msg(5'd3, 1'b0);
        wait_valid(60, n, flag);
        char_ready = 1'b0;
        vectors++; if (char_out !== 8'h4F) begin miscompares++; $display("[TB] FAIL bp_char_before: got %h, expected 4f", char_out); end
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (!(char_valid === 1'b1 && char_out === 8'h4F && char_idx === 4'd1)) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL bp_hold: got %0d unstable cycles, expected 0", bad); end
        char_ready = 1'b1;
        wait_valid(60, n, flag);
        vectors++; if (n != 19) begin miscompares++; $display("[TB] FAIL bp_resume_spacing: got %0d cycles, expected 19", n); end
        vectors++; if (char_out !== 8'h53) begin miscompares++; $display("[TB] FAIL bp_resume_char: got %h, expected 53", char_out); end
        vectors++; if (char_idx !== 4'd2) begin miscompares++; $display("[TB] FAIL bp_resume_idx: got %0d, expected 2", char_idx); end
        wait_done(60, n, flag);
        vectors++; if (n != 19) begin miscompares++; $display("[TB] FAIL bp_done_latency: got %0d cycles, expected 19", n); end
        step();
    endtask

    task automatic test_write_protect();
        int n;
        bit flag;
        char_ready = 1'b1;
        start_msg(5'd3, 1'b0);
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = 8'h5A;
        wait_valid(60, n, flag);
        wr_en = 1'b0;
        vectors++; if (char_out !== 8'h4F) begin miscompares++; $display("[TB] FAIL wp_second_char: got %h, expected 4f", char_out); end
        wait_valid(60, n, flag);
        vectors++; if (char_out !== 8'h53) begin miscompares++; $display("[TB] FAIL wp_protected_char: got %h, expected 53", char_out); end
        wait_done(60, n, flag);
        step();
        write_char(4'd2, 8'h5A);
        start_msg(5'd3, 1'b0);
        wait_valid(60, n, flag);
        wait_valid(60, n, flag);
        vectors++; if (char_out !== 8'h5A) begin miscompares++; $display("[TB] FAIL wp_idle_write: got %h, expected 5a", char_out); end
        vectors++; if (char_idx !== 4'd2) begin miscompares++; $display("[TB] FAIL wp_idle_write_idx: got %0d, expected 2", char_idx); end
        wait_done(60, n, flag);
        step();
        write_char(4'd2, 8'h53);
    endtask

    task automatic test_repeat_abort();
        int n;
        int bad;
        bit flag;
        write_char(4'd0, 8'h41);
        write_char(4'd1, 8'h42);
        char_ready = 1'b1;
        start_msg(5'd2, 1'b1);
        for (int k = 0; k < 5; k++) begin
            vectors++; if (char_out !== ab_exp[k]) begin miscompares++; $display("[TB] FAIL rep_char k=%0d: got %h, expected %h", k, char_out, ab_exp[k]); end
            vectors++; if (char_idx !== ab_idx[k]) begin miscompares++; $display("[TB] FAIL rep_idx k=%0d: got %0d, expected %0d", k, char_idx, ab_idx[k]); end
            if (k < 4) begin
                wait_valid(60, n, flag);
                vectors++; if (n != 19) begin miscompares++; $display("[TB] FAIL rep_spacing k=%0d: got %0d cycles, expected 19", k, n); end
                vectors++; if (flag !== 1'b0) begin miscompares++; $display("[TB] FAIL rep_done_seen k=%0d: got %b, expected 0", k, flag); end
            end
        end
        step();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rep_busy_in_gap: got %b, expected 1", busy); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b, expected 0", busy); end
        vectors++; if (char_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_valid: got %b, expected 0", char_valid); end
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            if (done !== 1'b0 || busy !== 1'b0 || char_valid !== 1'b0) bad++;
            step();
        end
        vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL abort_quiet: got %0d active cycles, expected 0", bad); end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL start_with_abort: got busy %b, expected 0", busy); end
        write_char(4'd0, 8'h53);
        write_char(4'd1, 8'h4F);
    endtask

    task automatic test_zero_len();
        start_msg(5'd0, 1'b0);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_done: got %b, expected 1", done); end
        vectors++; if (char_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_valid: got %b, expected 0", char_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_busy: got %b, expected 0", busy); end
        step();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_done_width: got %b, expected 0", done); end
        vectors++; if (char_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_valid_after: got %b, expected 0", char_valid); end
    endtask

    task automatic test_len_clamp();
        int n;
        bit flag;
        for (int i = 0; i < 16; i++) write_char(i[3:0], 8'h60 + i[7:0]);
        char_ready = 1'b1;
        start_msg(5'd31, 1'b0);
        for (int k = 0; k < 16; k++) begin
            vectors++; if (char_out !== 8'h60 + k[7:0]) begin miscompares++; $display("[TB] FAIL clamp_char k=%0d: got %h, expected %h", k, char_out, 8'h60 + k[7:0]); end
            vectors++; if (char_idx !== k[3:0]) begin miscompares++; $display("[TB] FAIL clamp_idx k=%0d: got %0d, expected %0d", k, char_idx, k); end
            if (k < 15) begin
                wait_valid(60, n, flag);
                vectors++; if (n != 19) begin miscompares++; $display("[TB] FAIL clamp_spacing k=%0d: got %0d cycles, expected 19", k, n); end
            end else begin
                wait_done(60, n, flag);
                vectors++; if (n != 19) begin miscompares++; $display("[TB] FAIL clamp_done_latency: got %0d cycles, expected 19", n); end
                vectors++; if (flag !== 1'b0) begin miscompares++; $display("[TB] FAIL clamp_extra_char: got %b, expected 0", flag); end
            end
        end
        step();
    endtask

    task automatic test_async_reset();
        int n;
        bit flag;
        write_char(4'd0, 8'h53);
        write_char(4'd1, 8'h4F);
        write_char(4'd2, 8'h53);
        char_ready = 1'b1;
        start_msg(5'd3, 1'b0);
        wait_valid(60, n, flag);
        for (int c = 0; c < 6; c++) step();
        vectors++; if (busy !== 1'b1 || char_valid !== 1'b0 || char_idx !== 4'd1) begin miscompares++; $display("[TB] FAIL areset_pre_gap: got busy %b valid %b idx %0d, expected 1 0 1", busy, char_valid, char_idx); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (char_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_valid: got %b, expected 0", char_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_busy: got %b, expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_done: got %b, expected 0", done); end
        vectors++; if (char_idx !== 4'd0) begin miscompares++; $display("[TB] FAIL areset_idx: got %0d, expected 0", char_idx); end
        #2;
        rst_n = 1'b1;
        step();
        start_msg(5'd3, 1'b0);
        vectors++; if (char_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_restart_valid: got %b, expected 1", char_valid); end
        vectors++; if (char_idx !== 4'd0) begin miscompares++; $display("[TB] FAIL areset_restart_idx: got %0d, expected 0", char_idx); end
        vectors++; if (char_out !== 8'h53) begin miscompares++; $display("[TB] FAIL areset_restart_char: got %h, expected 53", char_out); end
        wait_valid(60, n, flag);
        wait_valid(60, n, flag);
        wait_done(60, n, flag);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_restart_done: got %b, expected 1", done); end
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        msg_len    = '0;
        repeat_en  = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        char_ready = 1'b0;

        test_reset();
        test_sos();
        test_backpressure();
        test_write_protect();
        test_repeat_abort();
        test_zero_len();
        test_len_clamp();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
